// File: rtl/div_seq_if.sv
// Handshake and operand/result bundle between the execute stage and the sequential divider.
//   master: drives start/dividend/divisor, observes results and status
//   slave : the divider side
interface div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             exception;
    logic             result_rdy;
    logic             busy;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, exception, result_rdy, busy
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, exception, result_rdy, busy
    );
endinterface

// File: rtl/div_seq.sv
// Sequential signed divider: restoring shift-subtract, one quotient bit per cycle.
// Latency is WIDTH+1 cycles from the accepting edge, independent of operands.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   dif    : slave side of div_seq_if (start, operands in; quotient, remainder,
//            exception, result_rdy, busy out -- all outputs registered)
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clock,
    input  logic      resetn,
    div_seq_if.slave  dif
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic             ov;

    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             exception_q;
    logic             result_rdy_q;
    logic             busy_q;

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic             take;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] int_min;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (dif.start) state_n = ITER;
            ITER:    if (cnt == CW'(WIDTH - 1)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand magnitudes, one restoring step, and sign correction
    always_comb begin
        int_min = {1'b1, {(WIDTH-1){1'b0}}};
        abs_a   = dif.dividend[WIDTH-1] ? -dif.dividend : dif.dividend;
        abs_b   = dif.divisor[WIDTH-1]  ? -dif.divisor  : dif.divisor;
        // rem < |divisor| <= 2^(WIDTH-1), so the shifted value still fits WIDTH bits
        rem_sh  = {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo_sh  = {quo[WIDTH-2:0], 1'b0};
        take    = (rem_sh >= dsr);
        q_fix   = neg_q ? -quo : quo;
        r_fix   = neg_r ? -rem : rem;
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            quo          <= '0;
            rem          <= '0;
            dsr          <= '0;
            cnt          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            dz           <= 1'b0;
            ov           <= 1'b0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            exception_q  <= 1'b0;
            result_rdy_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            result_rdy_q <= (state == FIX);
            busy_q       <= (state_n != IDLE);
            case (state)
                IDLE: begin
                    if (dif.start) begin
                        quo   <= abs_a;
                        dsr   <= abs_b;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= dif.dividend[WIDTH-1] ^ dif.divisor[WIDTH-1];
                        neg_r <= dif.dividend[WIDTH-1];
                        dz    <= (dif.divisor == '0);
                        ov    <= (dif.dividend == int_min) && (dif.divisor == '1);
                    end
                end
                ITER: begin
                    rem <= take ? (rem_sh - dsr) : rem_sh;
                    quo <= {quo_sh[WIDTH-1:1], take};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    // Divide by zero leaves rem = |dividend|, which r_fix restores to the dividend
                    quotient_q  <= dz ? '0 : q_fix;
                    remainder_q <= r_fix;
                    exception_q <= dz | ov;
                end
                default: ;
            endcase
        end
    end

    assign dif.quotient   = quotient_q;
    assign dif.remainder  = remainder_q;
    assign dif.exception  = exception_q;
    assign dif.result_rdy = result_rdy_q;
    assign dif.busy       = busy_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized self-checking bench for div_seq (WIDTH = 32).
module tb_div_seq;
    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    div_seq_if #(.WIDTH(W)) dif ();

    div_seq #(.WIDTH(W)) dut (
        .clock  (clk),
        .resetn (rst_n),
        .dif    (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation, wait (bounded) for result_rdy, and report what was seen
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic e, output int lat,
                          output bit busy_ok, output bit single_pulse);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        dif.start    = 1'b0;
        dif.dividend = $urandom;
        dif.divisor  = $urandom;
        lat     = 0;
        busy_ok = 1'b1;
        while (dif.result_rdy !== 1'b1 && lat < 100) begin
            if (dif.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (dif.busy !== 1'b0) busy_ok = 1'b0;
        q = dif.quotient;
        r = dif.remainder;
        e = dif.exception;
        @(posedge clk);
        @(negedge clk);
        single_pulse = (dif.result_rdy === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dif.start = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;
        repeat (3) @(negedge clk);
        total_cnt++; if (dif.quotient !== 32'h0) $display("FAIL reset_quotient got %h want 0", dif.quotient); else pass_cnt++;
        total_cnt++; if (dif.remainder !== 32'h0) $display("FAIL reset_remainder got %h want 0", dif.remainder); else pass_cnt++;
        total_cnt++; if (dif.exception !== 1'b0) $display("FAIL reset_exception got %b want 0", dif.exception); else pass_cnt++;
        total_cnt++; if (dif.result_rdy !== 1'b0) $display("FAIL reset_result_rdy got %b want 0", dif.result_rdy); else pass_cnt++;
        total_cnt++; if (dif.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", dif.busy); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] q, r;
        logic e;
        int lat;
        bit bok, sp;
        run_op(32'd100, 32'd7, q, r, e, lat, bok, sp);
        total_cnt++; if (q !== 32'd14) $display("FAIL basic_quotient got %0d want 14", q); else pass_cnt++;
        total_cnt++; if (r !== 32'd2) $display("FAIL basic_remainder got %0d want 2", r); else pass_cnt++;
        total_cnt++; if (e !== 1'b0) $display("FAIL basic_exception got %b want 0", e); else pass_cnt++;
        total_cnt++; if (lat !== 33) $display("FAIL basic_latency got %0d want 33", lat); else pass_cnt++;
        total_cnt++; if (!bok) $display("FAIL basic_busy got bad busy window want high through E0+33"); else pass_cnt++;
        total_cnt++; if (!sp) $display("FAIL basic_rdy_pulse got rdy held want one-cycle pulse"); else pass_cnt++;
    endtask

    task automatic test_signs();
        logic [W-1:0] av[3] = '{32'hFFFFFF9C, 32'd100,      32'hFFFFFF9C};
        logic [W-1:0] bv[3] = '{32'd7,       32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [W-1:0] qv[3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
        logic [W-1:0] rv[3] = '{32'hFFFFFFFE, 32'd2,       32'hFFFFFFFE};
        logic [W-1:0] q, r;
        logic e;
        int lat;
        bit bok, sp;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], q, r, e, lat, bok, sp);
            total_cnt++; if (q !== qv[i]) $display("FAIL signs_quotient[%0d] got %h want %h", i, q, qv[i]); else pass_cnt++;
            total_cnt++; if (r !== rv[i]) $display("FAIL signs_remainder[%0d] got %h want %h", i, r, rv[i]); else pass_cnt++;
            total_cnt++; if (e !== 1'b0) $display("FAIL signs_exception[%0d] got %b want 0", i, e); else pass_cnt++;
        end
    endtask

    task automatic test_exceptions();
        logic [W-1:0] q, r;
        logic e;
        int lat;
        bit bok, sp;
        run_op(32'd5, 32'd0, q, r, e, lat, bok, sp);
        total_cnt++; if (q !== 32'd0) $display("FAIL dz_quotient got %h want 0", q); else pass_cnt++;
        total_cnt++; if (r !== 32'd5) $display("FAIL dz_remainder got %h want 5", r); else pass_cnt++;
        total_cnt++; if (e !== 1'b1) $display("FAIL dz_exception got %b want 1", e); else pass_cnt++;
        total_cnt++; if (lat !== 33) $display("FAIL dz_latency got %0d want 33", lat); else pass_cnt++;
        run_op(32'h80000000, 32'hFFFFFFFF, q, r, e, lat, bok, sp);
        total_cnt++; if (q !== 32'h80000000) $display("FAIL ov_quotient got %h want 80000000", q); else pass_cnt++;
        total_cnt++; if (r !== 32'd0) $display("FAIL ov_remainder got %h want 0", r); else pass_cnt++;
        total_cnt++; if (e !== 1'b1) $display("FAIL ov_exception got %b want 1", e); else pass_cnt++;
        total_cnt++; if (lat !== 33) $display("FAIL ov_latency got %0d want 33", lat); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int lat2;
        bit hold_ok;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 32'd50; dif.divisor = 32'd5;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        cyc = 0;
        while (dif.result_rdy !== 1'b1 && cyc < 100) begin
            // stray request accepted at E0+10 would be a bug: state is ITER
            dif.start = (cyc == 9);
            if (cyc == 9) begin dif.dividend = 32'd9; dif.divisor = 32'd2; end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        dif.start = 1'b0;
        total_cnt++; if (cyc !== 33) $display("FAIL b2b_first_latency got %0d want 33", cyc); else pass_cnt++;
        total_cnt++; if (dif.quotient !== 32'd10) $display("FAIL b2b_first_quotient got %0d want 10", dif.quotient); else pass_cnt++;
        total_cnt++; if (dif.remainder !== 32'd0) $display("FAIL b2b_first_remainder got %0d want 0", dif.remainder); else pass_cnt++;
        // issue the next request in the result_rdy cycle
        dif.start = 1'b1; dif.dividend = 32'd9; dif.divisor = 32'd2;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        lat2 = 0;
        hold_ok = 1'b1;
        while (dif.result_rdy !== 1'b1 && lat2 < 100) begin
            if (dif.quotient !== 32'd10 || dif.remainder !== 32'd0) hold_ok = 1'b0;
            @(posedge clk);
            lat2++;
            @(negedge clk);
        end
        total_cnt++; if (!hold_ok) $display("FAIL b2b_hold got changed outputs want 10 r 0 held"); else pass_cnt++;
        total_cnt++; if (lat2 !== 33) $display("FAIL b2b_second_latency got %0d want 33", lat2); else pass_cnt++;
        total_cnt++; if (dif.quotient !== 32'd4) $display("FAIL b2b_second_quotient got %0d want 4", dif.quotient); else pass_cnt++;
        total_cnt++; if (dif.remainder !== 32'd1) $display("FAIL b2b_second_remainder got %0d want 1", dif.remainder); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int nrdy;
        logic [W-1:0] q, r;
        logic e;
        int lat;
        bit bok, sp;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 32'd1000; dif.divisor = 32'd3;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({dif.quotient, dif.remainder, dif.exception, dif.result_rdy, dif.busy} !== 67'd0)
            $display("FAIL midreset_outputs got q=%h r=%h e=%b rdy=%b busy=%b want all 0",
                     dif.quotient, dif.remainder, dif.exception, dif.result_rdy, dif.busy);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        nrdy = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.result_rdy === 1'b1) nrdy++;
        end
        total_cnt++; if (nrdy !== 0) $display("FAIL midreset_no_rdy got %0d pulses want 0", nrdy); else pass_cnt++;
        run_op(32'd1000, 32'd3, q, r, e, lat, bok, sp);
        total_cnt++; if (q !== 32'd333) $display("FAIL midreset_quotient got %0d want 333", q); else pass_cnt++;
        total_cnt++; if (r !== 32'd1) $display("FAIL midreset_remainder got %0d want 1", r); else pass_cnt++;
        total_cnt++; if (lat !== 33) $display("FAIL midreset_latency got %0d want 33", lat); else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [W-1:0] corners[8] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000,
                                     32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd7};
        logic [W-1:0] a, b, q, r, eq, er, chk;
        logic signed [W-1:0] sa, sb;
        logic e, ee;
        longint abs_r, abs_b;
        int lat;
        bit bok, sp;
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)]
              : (($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 40)));
            sa = a;
            sb = b;
            if (b == 32'd0) begin
                eq = 32'd0; er = a; ee = 1'b1;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                eq = 32'h80000000; er = 32'd0; ee = 1'b1;
            end else begin
                eq = sa / sb; er = sa % sb; ee = 1'b0;
            end
            run_op(a, b, q, r, e, lat, bok, sp);
            total_cnt++; if (q !== eq) $display("FAIL sweep_quotient %h/%h got %h want %h", a, b, q, eq); else pass_cnt++;
            total_cnt++; if (r !== er) $display("FAIL sweep_remainder %h/%h got %h want %h", a, b, r, er); else pass_cnt++;
            total_cnt++; if (e !== ee) $display("FAIL sweep_exception %h/%h got %b want %b", a, b, e, ee); else pass_cnt++;
            total_cnt++; if (lat !== 33) $display("FAIL sweep_latency %h/%h got %0d want 33", a, b, lat); else pass_cnt++;
            if (!ee) begin
                chk = q * b + r;
                abs_r = (r[W-1]) ? -longint'($signed(r)) : longint'(r);
                abs_b = (b[W-1]) ? -longint'($signed(b)) : longint'(b);
                total_cnt++; if (chk !== a) $display("FAIL sweep_identity %h/%h got %h want %h", a, b, chk, a); else pass_cnt++;
                total_cnt++; if (!(abs_r < abs_b)) $display("FAIL sweep_rem_bound %h/%h got |r|=%0d want < %0d", a, b, abs_r, abs_b); else pass_cnt++;
            end
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        dif.start = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        test_reset();
        test_basic();
        test_signs();
        test_exceptions();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
